// File: rtl/ahb_master_if.sv
// AHB-Lite bus bundle between the ahb_master initiator and an AHB slave such as the AHB2APB bridge.
interface ahb_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] Haddr;
  logic [1:0]        Htrans;
  logic              Hwrite;
  logic [2:0]        Hsize;
  logic [2:0]        Hburst;
  logic [DATA_W-1:0] Hwdata;
  logic              Hreadyin;
  logic [1:0]        Hresp;
  logic [DATA_W-1:0] Hrdata;

  modport master (
    output Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata,
    input  Hreadyin, Hresp, Hrdata
  );

  modport slave (
    input  Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata,
    output Hreadyin, Hresp, Hrdata
  );
endinterface

// File: rtl/ahb_master.sv
// AHB-Lite initiator: turns single/incrementing-burst commands into pipelined AHB transfers,
// honouring wait states and ERROR responses, returning read data beat by beat.
module ahb_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  ahb_master_if.master      bus
);
  localparam int unsigned BW = LEN_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERRW} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hburst_q, hburst_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [BW-1:0]     beats_q, beats_d;

  logic              addr_phase, data_phase, err_hit;
  logic [ADDR_W-1:0] next_addr;

  assign addr_phase = (state_q == S_ADDR) || (state_q == S_BURST);
  assign data_phase = (state_q == S_BURST) || (state_q == S_LAST);
  // First ERROR cycle: slave stretches with Hreadyin low while signalling ERROR
  assign err_hit    = data_phase && (bus.Hresp != 2'b00) && !bus.Hreadyin;
  assign next_addr  = haddr_q + ADDR_W'(4);

  assign cmd_ready  = Hresetn && (state_q == S_IDLE);
  assign wr_pop     = addr_phase && bus.Hreadyin && hwrite_q;

  assign bus.Haddr  = haddr_q;
  assign bus.Htrans = htrans_q;
  assign bus.Hwrite = hwrite_q;
  assign bus.Hsize  = 3'b010;
  assign bus.Hburst = hburst_q;
  assign bus.Hwdata = hwdata_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign done       = done_q;
  assign err        = err_q;

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state_q    <= S_IDLE;
      haddr_q    <= '0;
      htrans_q   <= 2'b00;
      hwrite_q   <= 1'b0;
      hburst_q   <= 3'b000;
      hwdata_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      beats_q    <= '0;
    end else begin
      state_q    <= state_d;
      haddr_q    <= haddr_d;
      htrans_q   <= htrans_d;
      hwrite_q   <= hwrite_d;
      hburst_q   <= hburst_d;
      hwdata_q   <= hwdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      beats_q    <= beats_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_ADDR;
      S_ADDR:  if (bus.Hreadyin) state_d = (beats_q == BW'(1)) ? S_LAST : S_BURST;
      S_BURST: begin
        if (err_hit)           state_d = S_ERRW;
        else if (bus.Hreadyin) state_d = (beats_q == BW'(1)) ? S_LAST : S_BURST;
      end
      S_LAST: begin
        if (err_hit)           state_d = S_ERRW;
        else if (bus.Hreadyin) state_d = S_IDLE;
      end
      S_ERRW:  if (bus.Hreadyin) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    haddr_d    = haddr_q;
    htrans_d   = htrans_q;
    hwrite_d   = hwrite_q;
    hburst_d   = hburst_q;
    hwdata_d   = hwdata_q;
    rd_data_d  = rd_data_q;
    beats_d    = beats_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          haddr_d  = cmd_addr & ~ADDR_W'(3);
          hwrite_d = cmd_write;
          hburst_d = (cmd_len == '0) ? 3'b000 : 3'b001;
          htrans_d = 2'b10;
          beats_d  = BW'(cmd_len) + BW'(1);
        end
      end
      S_ADDR, S_BURST: begin
        if (err_hit) begin
          htrans_d = 2'b00;
        end else if (bus.Hreadyin) begin
          if (hwrite_q) hwdata_d = wr_data;
          if (data_phase && !hwrite_q) begin
            rd_data_d  = bus.Hrdata;
            rd_valid_d = 1'b1;
          end
          beats_d = beats_q - BW'(1);
          if (beats_q != BW'(1)) begin
            haddr_d  = next_addr;
            // A 1KB boundary must restart the burst as NONSEQ
            htrans_d = (next_addr[9:0] == 10'd0) ? 2'b10 : 2'b11;
          end else begin
            htrans_d = 2'b00;
          end
        end
      end
      S_LAST: begin
        if (err_hit) begin
          htrans_d = 2'b00;
        end else if (bus.Hreadyin) begin
          if (!hwrite_q) begin
            rd_data_d  = bus.Hrdata;
            rd_valid_d = 1'b1;
          end
          done_d = 1'b1;
        end
      end
      S_ERRW: begin
        if (bus.Hreadyin) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule
